// File: rtl/jtag_ir_param.sv
// JTAG instruction register: capture/shift stage plus a held update stage, with
// a shift-length guard and one-hot decode that drives the data-register mux.
module jtag_ir_param #(
  parameter int                  IR_WIDTH  = 4,
  parameter logic [IR_WIDTH-1:0] BYPASS_OP = '1,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] EXTEST_OP = IR_WIDTH'(0),
  parameter logic [IR_WIDTH-1:0] SAMPLE_OP = IR_WIDTH'(2)
) (
  input  logic                                      TCK,
  input  logic                                      RST,
  input  logic                                      TLR,
  input  logic                                      CAPTURE_IR,
  input  logic                                      SHIFT_IR,
  input  logic                                      UPDATE_IR,
  input  logic                                      TDI,
  input  logic [((IR_WIDTH > 2) ? IR_WIDTH-2 : 1)-1:0] STATUS,
  output logic                                      TDO,
  output logic [IR_WIDTH-1:0]                       INSTR,
  output logic                                      SEL_BYPASS,
  output logic                                      SEL_IDCODE,
  output logic                                      SEL_EXTEST,
  output logic                                      SEL_SAMPLE,
  output logic                                      SHORT_ERR
);

  localparam int CNT_W = $clog2(IR_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IR_WIDTH);

  logic [IR_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [IR_WIDTH-1:0] instr_reg;
  logic                short_err_reg;
  logic [IR_WIDTH-1:0] capture_val;

  // The two LSBs always capture 2'b01 so board-level tests can find IR length.
  generate
    if (IR_WIDTH > 2) begin : g_status
      assign capture_val = {STATUS, 2'b01};
    end else begin : g_no_status
      assign capture_val = 2'b01;
    end
  endgenerate

  always_ff @(posedge TCK) begin
    if (RST) begin
      shift_reg     <= '0;
      cnt_reg       <= '0;
      instr_reg     <= IDCODE_OP;
      short_err_reg <= 1'b0;
    end else if (TLR) begin
      cnt_reg       <= '0;
      instr_reg     <= IDCODE_OP;
      short_err_reg <= 1'b0;
    end else if (CAPTURE_IR) begin
      shift_reg     <= capture_val;
      cnt_reg       <= '0;
      short_err_reg <= 1'b0;
    end else if (SHIFT_IR) begin
      shift_reg <= {TDI, shift_reg[IR_WIDTH-1:1]};
      if (cnt_reg != FULL_CNT) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else if (UPDATE_IR) begin
      // A short shift leaves a partial opcode in shift_reg; never apply it.
      if (cnt_reg == FULL_CNT) begin
        instr_reg <= shift_reg;
      end else begin
        short_err_reg <= 1'b1;
      end
    end
  end

  logic is_idcode;
  logic is_extest;
  logic is_sample;

  // Priority chain keeps the select lines one-hot even if opcodes alias.
  assign is_idcode = (instr_reg == IDCODE_OP);
  assign is_extest = (instr_reg == EXTEST_OP) && !is_idcode;
  assign is_sample = (instr_reg == SAMPLE_OP) && !is_idcode && !is_extest;

  assign TDO        = shift_reg[0];
  assign INSTR      = instr_reg;
  assign SHORT_ERR  = short_err_reg;
  assign SEL_IDCODE = is_idcode;
  assign SEL_EXTEST = is_extest;
  assign SEL_SAMPLE = is_sample;
  assign SEL_BYPASS = !(is_idcode || is_extest || is_sample);

endmodule

// File: tb/tb_jtag_ir_param.sv
// Bench for jtag_ir_param: vector table through a scoreboard on a 4-bit IR,
// plus a hand-written capture/shift/update sequence on an 8-bit IR.
module tb_jtag_ir_param;

  logic       tck = 1'b0;
  always #5 tck = ~tck;

  // 4-bit instance
  logic       rst, tlr, cap, sh, upd, tdi;
  logic [1:0] status;
  logic       tdo, sel_bypass, sel_idcode, sel_extest, sel_sample, short_err;
  logic [3:0] instr;

  // 8-bit instance
  logic       rst8, tlr8, cap8, sh8, upd8, tdi8;
  logic [5:0] status8;
  logic       tdo8, sel_bypass8, sel_idcode8, sel_extest8, sel_sample8, short_err8;
  logic [7:0] instr8;

  jtag_ir_param #(.IR_WIDTH(4)) dut (
    .TCK(tck), .RST(rst), .TLR(tlr), .CAPTURE_IR(cap), .SHIFT_IR(sh),
    .UPDATE_IR(upd), .TDI(tdi), .STATUS(status), .TDO(tdo), .INSTR(instr),
    .SEL_BYPASS(sel_bypass), .SEL_IDCODE(sel_idcode), .SEL_EXTEST(sel_extest),
    .SEL_SAMPLE(sel_sample), .SHORT_ERR(short_err)
  );

  jtag_ir_param #(.IR_WIDTH(8), .BYPASS_OP(8'hFF)) dut8 (
    .TCK(tck), .RST(rst8), .TLR(tlr8), .CAPTURE_IR(cap8), .SHIFT_IR(sh8),
    .UPDATE_IR(upd8), .TDI(tdi8), .STATUS(status8), .TDO(tdo8), .INSTR(instr8),
    .SEL_BYPASS(sel_bypass8), .SEL_IDCODE(sel_idcode8), .SEL_EXTEST(sel_extest8),
    .SEL_SAMPLE(sel_sample8), .SHORT_ERR(short_err8)
  );

  typedef struct {
    logic [5:0] ctl;        // {rst, tlr, cap, sh, upd, tdi}
    logic [1:0] status;
    logic       exp_tdo;
    logic [3:0] exp_instr;
    logic [3:0] exp_sel;    // {bypass, idcode, extest, sample}
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic       tdo;
    logic [3:0] instr;
    logic [3:0] sel;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic [5:0] ctl, input logic [1:0] st,
                              input logic t, input logic [3:0] ins,
                              input logic [3:0] sel, input logic err);
    vec_t v;
    v.ctl = ctl; v.status = st; v.exp_tdo = t;
    v.exp_instr = ins; v.exp_sel = sel; v.exp_err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step8(input logic r, input logic t, input logic c, input logic s,
                       input logic u, input logic d);
    rst8 = r; tlr8 = t; cap8 = c; sh8 = s; upd8 = u; tdi8 = d;
    @(posedge tck);
    #1;
  endtask

  initial begin
    exp_t e;
    logic [7:0] cap_val8;

    rst = 0; tlr = 0; cap = 0; sh = 0; upd = 0; tdi = 0; status = 2'b00;
    rst8 = 0; tlr8 = 0; cap8 = 0; sh8 = 0; upd8 = 0; tdi8 = 0; status8 = 6'h2A;

    // reset
    vecs.push_back(mk(6'b100000, 2'b00, 1'b0, 4'b0001, 4'b0100, 1'b0));
    // capture 2'b10 then shift 0,1,0,0 -> SAMPLE
    vecs.push_back(mk(6'b001000, 2'b10, 1'b1, 4'b0001, 4'b0100, 1'b0));
    vecs.push_back(mk(6'b000100, 2'b00, 1'b0, 4'b0001, 4'b0100, 1'b0));
    vecs.push_back(mk(6'b000101, 2'b00, 1'b0, 4'b0001, 4'b0100, 1'b0));
    vecs.push_back(mk(6'b000100, 2'b00, 1'b1, 4'b0001, 4'b0100, 1'b0));
    vecs.push_back(mk(6'b000100, 2'b00, 1'b0, 4'b0001, 4'b0100, 1'b0));
    vecs.push_back(mk(6'b000010, 2'b00, 1'b0, 4'b0010, 4'b0001, 1'b0));
    vecs.push_back(mk(6'b000000, 2'b00, 1'b0, 4'b0010, 4'b0001, 1'b0));
    // short shift (3 bits) rejected, next capture clears the flag
    vecs.push_back(mk(6'b001000, 2'b00, 1'b1, 4'b0010, 4'b0001, 1'b0));
    vecs.push_back(mk(6'b000101, 2'b00, 1'b0, 4'b0010, 4'b0001, 1'b0));
    vecs.push_back(mk(6'b000101, 2'b00, 1'b0, 4'b0010, 4'b0001, 1'b0));
    vecs.push_back(mk(6'b000100, 2'b00, 1'b0, 4'b0010, 4'b0001, 1'b0));
    vecs.push_back(mk(6'b000010, 2'b00, 1'b0, 4'b0010, 4'b0001, 1'b1));
    vecs.push_back(mk(6'b001000, 2'b01, 1'b1, 4'b0010, 4'b0001, 1'b0));
    // over-long shift 1,1,1,0,1,0 -> 0101, undefined opcode -> BYPASS
    vecs.push_back(mk(6'b000101, 2'b00, 1'b0, 4'b0010, 4'b0001, 1'b0));
    vecs.push_back(mk(6'b000101, 2'b00, 1'b1, 4'b0010, 4'b0001, 1'b0));
    vecs.push_back(mk(6'b000101, 2'b00, 1'b0, 4'b0010, 4'b0001, 1'b0));
    vecs.push_back(mk(6'b000100, 2'b00, 1'b1, 4'b0010, 4'b0001, 1'b0));
    vecs.push_back(mk(6'b000101, 2'b00, 1'b1, 4'b0010, 4'b0001, 1'b0));
    vecs.push_back(mk(6'b000100, 2'b00, 1'b1, 4'b0010, 4'b0001, 1'b0));
    vecs.push_back(mk(6'b000010, 2'b00, 1'b1, 4'b0101, 4'b1000, 1'b0));
    // TLR mid-shift: IDCODE restored, following update rejected
    vecs.push_back(mk(6'b001000, 2'b11, 1'b1, 4'b0101, 4'b1000, 1'b0));
    vecs.push_back(mk(6'b000100, 2'b00, 1'b0, 4'b0101, 4'b1000, 1'b0));
    vecs.push_back(mk(6'b000100, 2'b00, 1'b1, 4'b0101, 4'b1000, 1'b0));
    vecs.push_back(mk(6'b010000, 2'b00, 1'b1, 4'b0001, 4'b0100, 1'b0));
    vecs.push_back(mk(6'b000010, 2'b00, 1'b1, 4'b0001, 4'b0100, 1'b1));
    // overlapping strobes: capture wins over shift and update
    vecs.push_back(mk(6'b001111, 2'b00, 1'b1, 4'b0001, 4'b0100, 1'b0));
    // shift EXTEST (all zeros) and update
    vecs.push_back(mk(6'b000100, 2'b00, 1'b0, 4'b0001, 4'b0100, 1'b0));
    vecs.push_back(mk(6'b000100, 2'b00, 1'b0, 4'b0001, 4'b0100, 1'b0));
    vecs.push_back(mk(6'b000100, 2'b00, 1'b0, 4'b0001, 4'b0100, 1'b0));
    vecs.push_back(mk(6'b000100, 2'b00, 1'b0, 4'b0001, 4'b0100, 1'b0));
    vecs.push_back(mk(6'b000010, 2'b00, 1'b0, 4'b0000, 4'b0010, 1'b0));
    // reset during a shift (with update overlapping): no partial update
    vecs.push_back(mk(6'b000101, 2'b00, 1'b0, 4'b0000, 4'b0010, 1'b0));
    vecs.push_back(mk(6'b100010, 2'b00, 1'b0, 4'b0001, 4'b0100, 1'b0));
    vecs.push_back(mk(6'b000010, 2'b00, 1'b0, 4'b0001, 4'b0100, 1'b1));

    @(posedge tck);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      {rst, tlr, cap, sh, upd, tdi} = vecs[i].ctl;
      status = vecs[i].status;
      e.tdo = vecs[i].exp_tdo; e.instr = vecs[i].exp_instr;
      e.sel = vecs[i].exp_sel; e.err = vecs[i].exp_err;
      exp_q.push_back(e);
      @(posedge tck);
      #1;
      e = exp_q.pop_front();
      $display("vec %0d: ctl=%b tdo=%b instr=%b sel=%b err=%b", i, vecs[i].ctl,
               tdo, instr, {sel_bypass, sel_idcode, sel_extest, sel_sample}, short_err);
      check($sformatf("v%0d_tdo", i), {7'd0, tdo}, {7'd0, e.tdo});
      check($sformatf("v%0d_instr", i), {4'd0, instr}, {4'd0, e.instr});
      check($sformatf("v%0d_sel", i),
            {4'd0, sel_bypass, sel_idcode, sel_extest, sel_sample}, {4'd0, e.sel});
      check($sformatf("v%0d_err", i), {7'd0, short_err}, {7'd0, e.err});
    end
    rst = 0; tlr = 0; cap = 0; sh = 0; upd = 0; tdi = 0;

    // 8-bit IR: capture pattern streaming and a full BYPASS shift
    cap_val8 = {6'h2A, 2'b01};
    step8(1, 0, 0, 0, 0, 0);
    $display("w8 reset: instr=%h sel_idcode=%b", instr8, sel_idcode8);
    check("w8_reset_instr", instr8, 8'h01);
    step8(0, 0, 1, 0, 0, 0);
    $display("w8 capture: tdo=%b", tdo8);
    check("w8_cap_tdo0", {7'd0, tdo8}, {7'd0, cap_val8[0]});
    for (int i = 1; i <= 8; i++) begin
      step8(0, 0, 0, 1, 0, 1);
      $display("w8 shift %0d: tdo=%b", i, tdo8);
      if (i < 8) check($sformatf("w8_tdo%0d", i), {7'd0, tdo8}, {7'd0, cap_val8[i]});
      else       check("w8_tdo_ones", {7'd0, tdo8}, 8'd1);
    end
    step8(0, 0, 0, 0, 1, 0);
    $display("w8 update: instr=%h sel_bypass=%b err=%b", instr8, sel_bypass8, short_err8);
    check("w8_instr", instr8, 8'hFF);
    check("w8_sel",
          {4'd0, sel_bypass8, sel_idcode8, sel_extest8, sel_sample8}, 8'b0000_1000);
    check("w8_err", {7'd0, short_err8}, 8'd0);
    step8(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
